// File: rtl/fifo_rr_wr_arb_pkg.sv
// Shared types, limits and helpers for the round-robin FIFO write-port arbiter.
// The optional source-tag feature is selected by the FIFO_ARB_SRC_TAG_EN macro.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_st_t;

  localparam int MAX_NREQ = 16;

`ifdef FIFO_ARB_SRC_TAG_EN
  localparam bit SRC_TAG_EN = 1'b1;
`else
  localparam bit SRC_TAG_EN = 1'b0;
`endif

  // Width of the FIFO write data: the payload, plus the source index on top when tagging.
  function automatic int wrdata_width(int data_w, int idx_w);
    return SRC_TAG_EN ? data_w + idx_w : data_w;
  endfunction

  // Modulo-n increment that also wraps correctly when n is not a power of 2.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_wr_arb_if.sv
// Handshake bundle between NREQ requesters, the arbiter and the FIFO write port.
// Signals:
//   i_req_valid/i_req_last/i_req_data : requester beats (data packed, k at [k*DATA_W +: DATA_W])
//   o_req_ready                       : per-requester accept
//   i_fifo_full                       : FIFO backpressure
//   o_fifo_wren/o_fifo_wrdata         : FIFO write port (wrdata widened by IDX_W
//                                       when FIFO_ARB_SRC_TAG_EN is defined)
//   o_grant_idx/o_busy                : current grant and mid-packet lock flag
// Modports: slave = arbiter side, master = requester/FIFO side.
interface fifo_rr_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 4,
  parameter int IDX_W  = $clog2(NREQ)
) ();

  localparam int OUT_W = wrdata_width(DATA_W, IDX_W);

  logic [NREQ-1:0]        i_req_valid;
  logic [NREQ-1:0]        i_req_last;
  logic [NREQ*DATA_W-1:0] i_req_data;
  logic [NREQ-1:0]        o_req_ready;
  logic                   i_fifo_full;
  logic                   o_fifo_wren;
  logic [OUT_W-1:0]       o_fifo_wrdata;
  logic [IDX_W-1:0]       o_grant_idx;
  logic                   o_busy;

  modport slave (
    input  i_req_valid, i_req_last, i_req_data, i_fifo_full,
    output o_req_ready, o_fifo_wren, o_fifo_wrdata, o_grant_idx, o_busy
  );

  modport master (
    output i_req_valid, i_req_last, i_req_data, i_fifo_full,
    input  o_req_ready, o_fifo_wren, o_fifo_wrdata, o_grant_idx, o_busy
  );

endinterface

// File: rtl/fifo_rr_wr_arb_rr_prio_enc.sv
// Combinational rotating-base priority encoder.
// Ports:
//   req     : request vector
//   base    : index scanned first; scan continues base+1 .. NREQ-1, 0 ..
//   gnt_idx : first requesting index found
//   gnt_vld : at least one request present
module rr_prio_enc #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDX_W'((32'(base) + i) % 32'(NREQ));
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arb.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port among NREQ requesters.
// A multi-beat packet locks the grant until its last beat so packets never interleave.
// Outputs are combinational from state and inputs; all outputs are forced low in reset.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_rr_wr_arb_if.slave (requester handshakes + FIFO write port)
// Optional: FIFO_ARB_SRC_TAG_EN prepends the granted index to the written data.
module fifo_rr_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 4,
  parameter int IDX_W  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rr_wr_arb_if.slave  bus
);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("fifo_rr_wr_arb: NREQ out of range");
  end

  arb_st_t          st_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_vld;
  logic [IDX_W-1:0] g;
  logic             g_vld;
  logic             wren;
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign data_arr[k] = bus.i_req_data[k*DATA_W +: DATA_W];
  end

  rr_prio_enc #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req     (bus.i_req_valid),
    .base    (rr_ptr_q),
    .gnt_idx (enc_idx),
    .gnt_vld (enc_vld)
  );

  // While locked, the grant stays with the packet owner even if it drops valid.
  always_comb begin
    g     = (st_q == ARB_LOCK) ? lock_idx_q : enc_idx;
    g_vld = (st_q == ARB_LOCK) || enc_vld;
    wren  = !rst && g_vld && !bus.i_fifo_full && bus.i_req_valid[g];
  end

  always_comb begin
    bus.o_req_ready   = '0;
    bus.o_fifo_wren   = 1'b0;
    bus.o_fifo_wrdata = '0;
    bus.o_grant_idx   = '0;
    bus.o_busy        = 1'b0;
    if (!rst) begin
      if (g_vld && !bus.i_fifo_full) begin
        bus.o_req_ready[g] = 1'b1;
      end
      bus.o_fifo_wren = wren;
      bus.o_grant_idx = g;
      bus.o_busy      = (st_q == ARB_LOCK);
      if (wren) begin
`ifdef FIFO_ARB_SRC_TAG_EN
        bus.o_fifo_wrdata = {g, data_arr[g]};
`else
        bus.o_fifo_wrdata = data_arr[g];
`endif
      end
    end
  end

  // State moves only on an accepted beat; rr_ptr points past the last served packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ARB_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else if (wren) begin
      case (st_q)
        ARB_IDLE: begin
          if (bus.i_req_last[g]) begin
            rr_ptr_q <= IDX_W'(wrap_inc(32'(g), NREQ));
          end else begin
            st_q       <= ARB_LOCK;
            lock_idx_q <= g;
          end
        end
        ARB_LOCK: begin
          if (bus.i_req_last[g]) begin
            st_q     <= ARB_IDLE;
            rr_ptr_q <= IDX_W'(wrap_inc(32'(lock_idx_q), NREQ));
          end
        end
        default: st_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arb.sv
// Directed self-checking bench for fifo_rr_wr_arb (NREQ=4 and NREQ=3 instances).
module tb_fifo_rr_wr_arb;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_rr_wr_arb_if #(.NREQ(4), .DATA_W(4)) b4 ();
  fifo_rr_wr_arb_if #(.NREQ(3), .DATA_W(4)) b3 ();

  fifo_rr_wr_arb #(.NREQ(4), .DATA_W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  fifo_rr_wr_arb #(.NREQ(3), .DATA_W(4)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input int g, input int p);
`ifdef FIFO_ARB_SRC_TAG_EN
    return 32'(g * 16 + p);
`else
    return 32'(p);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b4.i_req_valid = 4'hF;
    b4.i_req_last  = 4'hF;
    b4.i_req_data  = 16'h4321;
    b4.i_fifo_full = 1'b0;
    b3.i_req_valid = 3'b000;
    b3.i_req_last  = 3'b111;
    b3.i_req_data  = 12'h987;
    b3.i_fifo_full = 1'b0;

    // Reset with every requester valid: all outputs low.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ready", 32'(b4.o_req_ready), 32'h0);
      chk("rst_wren",  32'(b4.o_fifo_wren), 32'h0);
      chk("rst_wdata", 32'(b4.o_fifo_wrdata), 32'h0);
      chk("rst_grant", 32'(b4.o_grant_idx), 32'h0);
      chk("rst_busy",  32'(b4.o_busy), 32'h0);
      tick();
    end
    rst = 1'b0;

    // Fairness: single-beat packets from everyone -> 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fair_grant", 32'(b4.o_grant_idx), 32'(i % 4));
      chk("fair_ready", 32'(b4.o_req_ready), 32'(1 << (i % 4)));
      chk("fair_wren",  32'(b4.o_fifo_wren), 32'h1);
      chk("fair_wdata", 32'(b4.o_fifo_wrdata), exp_wd(i % 4, i % 4 + 1));
      tick();
    end

    // Serve req0 so rr_ptr lands on 1.
    b4.i_req_valid = 4'b0001;
    b4.i_req_last  = 4'b0001;
    #1;
    chk("pre_grant", 32'(b4.o_grant_idx), 32'h0);
    tick();

    // Packet lock: req1 sends A,B,C while req2 waits.
    b4.i_req_valid = 4'b0110;
    b4.i_req_last  = 4'b0000;
    b4.i_req_data  = 16'h0DA0;
    #1;
    chk("pktA_grant", 32'(b4.o_grant_idx), 32'h1);
    chk("pktA_ready", 32'(b4.o_req_ready), 32'h2);
    chk("pktA_wdata", 32'(b4.o_fifo_wrdata), exp_wd(1, 4'hA));
    chk("pktA_busy",  32'(b4.o_busy), 32'h0);
    tick();
    b4.i_req_data = 16'h0DB0;
    #1;
    chk("pktB_grant", 32'(b4.o_grant_idx), 32'h1);
    chk("pktB_wdata", 32'(b4.o_fifo_wrdata), exp_wd(1, 4'hB));
    chk("pktB_busy",  32'(b4.o_busy), 32'h1);
    tick();

    // Backpressure mid-packet for 4 cycles.
    b4.i_req_data  = 16'h0DC0;
    b4.i_req_last  = 4'b0010;
    b4.i_fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_ready", 32'(b4.o_req_ready), 32'h0);
      chk("full_wren",  32'(b4.o_fifo_wren), 32'h0);
      chk("full_busy",  32'(b4.o_busy), 32'h1);
      chk("full_grant", 32'(b4.o_grant_idx), 32'h1);
      tick();
    end
    b4.i_fifo_full = 1'b0;
    #1;
    chk("pktC_wren",  32'(b4.o_fifo_wren), 32'h1);
    chk("pktC_wdata", 32'(b4.o_fifo_wrdata), exp_wd(1, 4'hC));
    chk("pktC_busy",  32'(b4.o_busy), 32'h1);
    tick();
    b4.i_req_valid = 4'b0100;
    b4.i_req_last  = 4'b0100;
    #1;
    chk("after_grant", 32'(b4.o_grant_idx), 32'h2);
    chk("after_wdata", 32'(b4.o_fifo_wrdata), exp_wd(2, 4'hD));
    chk("after_busy",  32'(b4.o_busy), 32'h0);
    tick();

    // req3 starts a packet, then drops valid: lock holds, others stall.
    b4.i_req_valid = 4'b1000;
    b4.i_req_last  = 4'b0000;
    b4.i_req_data  = 16'h7000;
    #1;
    chk("l3_grant", 32'(b4.o_grant_idx), 32'h3);
    chk("l3_wdata", 32'(b4.o_fifo_wrdata), exp_wd(3, 7));
    tick();
    b4.i_req_valid = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_ready", 32'(b4.o_req_ready), 32'h8);
      chk("drop_wren",  32'(b4.o_fifo_wren), 32'h0);
      chk("drop_busy",  32'(b4.o_busy), 32'h1);
      chk("drop_grant", 32'(b4.o_grant_idx), 32'h3);
      tick();
    end

    // Reset mid-lock drops the lock and rr_ptr.
    rst = 1'b1;
    #1;
    chk("mrst_busy",  32'(b4.o_busy), 32'h0);
    chk("mrst_ready", 32'(b4.o_req_ready), 32'h0);
    tick();
    rst = 1'b0;
    b4.i_req_valid = 4'hF;
    b4.i_req_last  = 4'hF;
    #1;
    chk("prst_busy",  32'(b4.o_busy), 32'h0);
    chk("prst_grant", 32'(b4.o_grant_idx), 32'h0);
    tick();
    b4.i_req_valid = 4'b1000;
    b4.i_req_last  = 4'b1000;
    b4.i_req_data  = 16'h5000;
    #1;
    chk("tag_grant", 32'(b4.o_grant_idx), 32'h3);
    chk("tag_wren",  32'(b4.o_fifo_wren), 32'h1);
    chk("tag_wdata", 32'(b4.o_fifo_wrdata), exp_wd(3, 5));
    tick();

    // NREQ=3 wrap: rr_ptr 2 -> 0 -> 1.
    b3.i_req_valid = 3'b010;
    #1;
    chk("w3_g1", 32'(b3.o_grant_idx), 32'h1);
    chk("w3_d1", 32'(b3.o_fifo_wrdata), exp_wd(1, 8));
    tick();
    b3.i_req_valid = 3'b101;
    #1;
    chk("w3_g2",  32'(b3.o_grant_idx), 32'h2);
    chk("w3_r2",  32'(b3.o_req_ready), 32'h4);
    chk("w3_d2",  32'(b3.o_fifo_wrdata), exp_wd(2, 9));
    tick();
    #1;
    chk("w3_g0", 32'(b3.o_grant_idx), 32'h0);
    chk("w3_d0", 32'(b3.o_fifo_wrdata), exp_wd(0, 7));
    tick();
    b3.i_req_valid = 3'b111;
    #1;
    chk("w3_gnext", 32'(b3.o_grant_idx), 32'h1);
    chk("w3_rnext", 32'(b3.o_req_ready), 32'h2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
